// File: rtl/parallel2serial_pkg.sv
// p2s_pkg: state encoding, default parameters and counter sizing shared by the
// parallel-to-serial transmitter.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } p2s_state_t;

  localparam int P2S_DEFAULT_WIDTH    = 8;
  localparam int P2S_DEFAULT_IDLE_GAP = 0;

  // IDLE_GAP is limited to 0..15, so four bits always hold the gap count.
  localparam int P2S_GAP_CNT_W = 4;

  // Bit counter must reach WIDTH when the parity cycle is appended.
  function automatic int p2s_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parallel2serial.sv
// parallel2serial: valid/ready loaded word shifted out LSB first on d, framed by serial_start.
// Build macro P2S_PARITY_EN appends an even-parity bit (state PAR) to every frame.
module parallel2serial
  import p2s_pkg::*;
#(
  parameter int WIDTH    = P2S_DEFAULT_WIDTH,
  parameter int IDLE_GAP = P2S_DEFAULT_IDLE_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_start,
  output logic             d,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = p2s_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [P2S_GAP_CNT_W-1:0] GAP_ONE = P2S_GAP_CNT_W'(1);
  localparam logic [P2S_GAP_CNT_W-1:0] GAP_LOAD =
    (IDLE_GAP > 0) ? P2S_GAP_CNT_W'(IDLE_GAP - 1) : '0;

  p2s_state_t               r_state, w_state_next;
  logic [WIDTH-1:0]         r_shift, w_shift_next;
  logic [CNT_W-1:0]         r_cnt, w_cnt_next;
  logic [P2S_GAP_CNT_W-1:0] r_gap, w_gap_next;
  logic                     r_d, w_d_next;
  logic                     w_last;
  logic                     w_ready;
  logic                     w_accept;

`ifdef P2S_PARITY_EN
  logic r_par, w_par_next;
  assign w_last = (r_state == PAR);
`else
  assign w_last = (r_state == SHIFT) && (r_cnt == LAST_DATA_IDX);
`endif

  // With no gap the final-bit cycle also accepts, giving back-to-back frames.
  assign w_ready  = (r_state == IDLE) || ((IDLE_GAP == 0) && w_last);
  assign w_accept = load_valid && load_ready;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_gap_next   = r_gap;
`ifdef P2S_PARITY_EN
    w_par_next   = r_par;
`endif

    case (r_state)
      IDLE: begin
        w_state_next = IDLE;
      end
      SHIFT: begin
        if (r_cnt == LAST_DATA_IDX) begin
`ifdef P2S_PARITY_EN
          w_state_next = PAR;
          w_cnt_next   = r_cnt + CNT_ONE;
`endif
        end else begin
          w_shift_next = r_shift >> 1;
          w_cnt_next   = r_cnt + CNT_ONE;
        end
      end
      PAR: begin
        w_state_next = PAR;
      end
      GAP: begin
        if (r_gap == '0) begin
          w_state_next = IDLE;
        end else begin
          w_gap_next = r_gap - GAP_ONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_last) begin
      w_shift_next = '0;
      w_cnt_next   = '0;
      if (IDLE_GAP > 0) begin
        w_state_next = GAP;
        w_gap_next   = GAP_LOAD;
      end else begin
        w_state_next = IDLE;
      end
    end

    // An accept always starts a fresh frame, including the back-to-back case.
    if (w_accept) begin
      w_state_next = SHIFT;
      w_shift_next = load_data;
      w_cnt_next   = '0;
`ifdef P2S_PARITY_EN
      w_par_next   = ^load_data;
`endif
    end
  end

  // d is a plain flop: compute next cycle's line value from the next state.
  always_comb begin
    w_d_next = 1'b0;
    if (w_state_next == SHIFT) begin
      w_d_next = w_shift_next[0];
    end
`ifdef P2S_PARITY_EN
    else if (w_state_next == PAR) begin
      w_d_next = r_par;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_d     <= 1'b0;
`ifdef P2S_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_gap   <= w_gap_next;
      r_d     <= w_d_next;
`ifdef P2S_PARITY_EN
      r_par   <= w_par_next;
`endif
    end
  end

  // IDLE is the reset state, so ready must be masked while rst is held.
  assign load_ready   = w_ready && !rst;
  assign serial_start = (r_state == SHIFT) && (r_cnt == '0);
  assign d            = r_d;
  assign busy         = (r_state != IDLE);
  assign done         = w_last;

endmodule

// File: tb/tb_parallel2serial.sv
// tb_parallel2serial: two transmitters (IDLE_GAP 0 and 3) against a cycle-schedule
// reference model plus a serial loopback receiver; honours P2S_PARITY_EN.
`timescale 1ns/1ps
module tb_parallel2serial;

  localparam int W  = 8;
`ifdef P2S_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int L  = W + PAR_EN;
  localparam int NI = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [NI-1:0] o_ready, o_start, o_d, o_busy, o_done;

  always #5 clk = ~clk;

  parallel2serial #(.WIDTH(W), .IDLE_GAP(0)) u_dut_nogap (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(o_ready[0]), .serial_start(o_start[0]), .d(o_d[0]),
    .busy(o_busy[0]), .done(o_done[0])
  );

  parallel2serial #(.WIDTH(W), .IDLE_GAP(3)) u_dut_gap (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(o_ready[1]), .serial_start(o_start[1]), .d(o_d[1]),
    .busy(o_busy[1]), .done(o_done[1])
  );

  int gap_cfg [NI] = '{0, 3};
  int t = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference schedule: frame bits occupy [m_start, m_start+L), busy through m_busy_until.
  int           m_start      [NI];
  int           m_busy_until [NI];
  logic [W-1:0] m_word       [NI];
  bit           last_acc     [NI];
  logic [W-1:0] sent_q0 [$];
  logic [W-1:0] sent_q1 [$];

  bit           rx_active [NI];
  int           rx_idx    [NI];
  logic [W-1:0] rx_word   [NI];
  logic         rx_par    [NI];
  int           obs_start_prev [NI];
  int           obs_start_last [NI];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Expected {load_ready, serial_start, d, busy, done} for instance i in cycle tc.
  function automatic logic [4:0] model_outs(input int i, input int tc);
    int           k;
    bit           in_frame;
    logic [W-1:0] sh;
    logic [4:0]   o;
    k        = tc - m_start[i];
    in_frame = (k >= 0) && (k < L);
    o        = '0;
    o[1]     = (tc <= m_busy_until[i]);
    o[4]     = (tc > m_busy_until[i]) || (gap_cfg[i] == 0 && in_frame && k == L - 1);
    if (in_frame) begin
      sh   = m_word[i] >> k;
      o[3] = (k == 0);
      o[2] = (k < W) ? sh[0] : ^m_word[i];
      o[0] = (k == L - 1);
    end
    return o;
  endfunction

  function automatic bit model_step(input int i, input logic v, input logic [W-1:0] dat);
    logic [4:0] e;
    e = model_outs(i, t);
    if (v && e[4]) begin
      m_start[i]      = t + 1;
      m_busy_until[i] = t + L + gap_cfg[i];
      m_word[i]       = dat;
      if (i == 0) sent_q0.push_back(dat);
      else        sent_q1.push_back(dat);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_start[i]        = -1000;
      m_busy_until[i]   = -1000;
      m_word[i]         = '0;
      last_acc[i]       = 1'b0;
      rx_active[i]      = 1'b0;
      rx_idx[i]         = 0;
      rx_word[i]        = '0;
      rx_par[i]         = 1'b0;
      obs_start_prev[i] = 0;
      obs_start_last[i] = 0;
    end
    sent_q0.delete();
    sent_q1.delete();
  endtask

  task automatic loopback_done(input int i);
    logic [W-1:0] want;
    int           qsz;
    qsz = (i == 0) ? sent_q0.size() : sent_q1.size();
    if (qsz == 0) begin
      check_eq($sformatf("loop_unexpected_g%0d_t%0d", gap_cfg[i], t), 32'd1, 32'd0);
    end else begin
      want = (i == 0) ? sent_q0.pop_front() : sent_q1.pop_front();
      check_eq($sformatf("loop_word_g%0d_t%0d", gap_cfg[i], t), 32'(rx_word[i]), 32'(want));
      check_eq($sformatf("loop_len_g%0d_t%0d", gap_cfg[i], t), 32'(rx_idx[i]), 32'(L));
`ifdef P2S_PARITY_EN
      check_eq($sformatf("loop_par_g%0d_t%0d", gap_cfg[i], t), 32'(rx_par[i]), 32'(^want));
`endif
    end
  endtask

  task automatic sample_and_check();
    for (int i = 0; i < NI; i++) begin
      logic [4:0] obs;
      logic [4:0] want;
      obs  = {o_ready[i], o_start[i], o_d[i], o_busy[i], o_done[i]};
      want = model_outs(i, t);
      check_eq($sformatf("outs_rdy_st_d_bsy_dn_g%0d_t%0d", gap_cfg[i], t), 32'(obs), 32'(want));
      if (o_start[i]) begin
        obs_start_prev[i] = obs_start_last[i];
        obs_start_last[i] = t;
        rx_active[i]      = 1'b1;
        rx_idx[i]         = 0;
      end
      if (rx_active[i]) begin
        if (rx_idx[i] < W) rx_word[i] = {o_d[i], rx_word[i][W-1:1]};
        else               rx_par[i]  = o_d[i];
        rx_idx[i]++;
        if (o_done[i]) begin
          rx_active[i] = 1'b0;
          loopback_done(i);
        end
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] dat);
    @(negedge clk);
    sample_and_check();
    load_valid = v;
    load_data  = dat;
    for (int i = 0; i < NI; i++) last_acc[i] = model_step(i, v, dat);
    @(posedge clk);
    t++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0);
  endtask

  task automatic hold_until(input int i, input logic [W-1:0] dat);
    int n;
    n = 0;
    do begin
      cycle(1'b1, dat);
      n++;
    end while (!last_acc[i] && n < 40);
    if (!last_acc[i]) check_eq($sformatf("accept_timeout_g%0d", gap_cfg[i]), 32'd0, 32'd1);
  endtask

  task automatic run_to_bit(input int k);
    int n;
    n = 0;
    while (t < m_start[0] + k && n < 40) begin
      cycle(1'b0, '0);
      n++;
    end
    check_eq("reach_bit", 32'(t - m_start[0]), 32'(k));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("%s_g%0d", tag, gap_cfg[i]),
               32'({o_ready[i], o_start[i], o_d[i], o_busy[i], o_done[i]}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1 check_all_zero("reset_t0");
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;

    // Single frame, then the parity-demonstration word.
    hold_until(0, 8'b01001101);
    idle(16);
    hold_until(0, 8'h07);
    idle(16);

    // Back-to-back frames on the gapless instance.
    hold_until(0, 8'hA5);
    hold_until(0, 8'h3C);
    idle(20);
    check_eq("b2b_spacing", 32'(obs_start_last[0] - obs_start_prev[0]), 32'(L));

    // Two frames through the gapped instance.
    hold_until(1, 8'h96);
    hold_until(1, 8'h5A);
    idle(24);
    check_eq("gap_spacing", 32'(obs_start_last[1] - obs_start_prev[1]), 32'(L + 3 + 1));

    // Load request while busy is ignored until load_ready.
    cycle(1'b1, 8'h00);
    run_to_bit(3);
    hold_until(0, 8'hFF);
    hold_until(1, 8'hFF);
    idle(24);

    // Asynchronous reset during bit 4 drops the frame.
    cycle(1'b1, 8'hC3);
    run_to_bit(4);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_mid_hold");
    rst = 1'b0;
    load_valid = 1'b0;
    model_reset();
    idle(12);

    // Random traffic.
    repeat (400) cycle(1'($urandom_range(0, 1)), W'($urandom));
    idle(24);
    check_eq("drain_nogap", 32'(sent_q0.size()), 32'd0);
    check_eq("drain_gap", 32'(sent_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
